// File: rtl/bsg_router_link_traffic_gen_if.sv
// Link bundle between the traffic generator and a router port.
// link_i carries router -> generator traffic, link_o carries generator -> router.
// Each is packed as {v, data[width_p-1:0], ready_and_rev}.
interface bsg_router_link_traffic_gen_if #(
    parameter int width_p = 128
) ();
    localparam int lw = width_p + 2;

    logic [lw-1:0] link_i;
    logic [lw-1:0] link_o;

    // Generator side: sends on link_o, receives on link_i.
    modport master (
        input  link_i,
        output link_o
    );

    // Router side: the mirror image.
    modport slave (
        input  link_o,
        output link_i
    );
endinterface

// File: rtl/bsg_router_link_traffic_gen.sv
// Router link traffic generator and monitor.
// It sends a programmed number of sequence-numbered packets to (dest_x, dest_y)
// on a ready/valid-and link. It also counts and signs every beat it receives.
// Optional receive-order checker: define BSG_ROUTER_TGEN_CHECK_EN to enable it.
// When it is not defined, error_o is tied low.
module bsg_router_link_traffic_gen #(
    parameter int width_p        = 128,
    parameter int x_cord_width_p = 5,
    parameter int y_cord_width_p = 5,
    parameter int count_width_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic [count_width_p-1:0]  num_pkts_i,
    input  logic [x_cord_width_p-1:0] dest_x_i,
    input  logic [y_cord_width_p-1:0] dest_y_i,
    bsg_router_link_traffic_gen_if.master link,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  sent_o,
    output logic [count_width_p-1:0]  recvd_o,
    output logic [31:0]               sig_o,
    output logic                      error_o
);
    localparam int lw      = width_p + 2;
    localparam int coord_w = x_cord_width_p + y_cord_width_p;
    localparam logic [count_width_p-1:0] cnt_one  = count_width_p'(1);
    localparam logic [count_width_p-1:0] cnt_zero = count_width_p'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Packet layout: dest_x in the low bits, dest_y above it, then the seq number.
    function automatic logic [width_p-1:0] pack_f(
        input logic [count_width_p-1:0]  seq,
        input logic [y_cord_width_p-1:0] dy,
        input logic [x_cord_width_p-1:0] dx
    );
        logic [width_p-1:0] pkt;
        pkt = '0;
        pkt[x_cord_width_p-1:0]              = dx;
        pkt[x_cord_width_p +: y_cord_width_p] = dy;
        pkt[coord_w +: count_width_p]         = seq;
        return pkt;
    endfunction

    // Rotate-left-by-one signature step folded with the low received word.
    function automatic logic [31:0] sig_step_f(
        input logic [31:0] sig,
        input logic [31:0] word
    );
        return {sig[30:0], sig[31]} ^ word;
    endfunction

    state_e                      state_r, state_s;
    logic [count_width_p-1:0]    num_r, num_s;
    logic [x_cord_width_p-1:0]   dest_x_r, dest_x_s;
    logic [y_cord_width_p-1:0]   dest_y_r, dest_y_s;
    logic [count_width_p-1:0]    sent_r, sent_s;
    logic                        v_r, v_s;
    logic [width_p-1:0]          data_r, data_s;
    logic                        rdy_r;
    logic [count_width_p-1:0]    recvd_r, recvd_s;
    logic [31:0]                 sig_r, sig_s;

    logic                        start_ok_s;
    logic                        xfer_s;
    logic                        rx_v_s;
    logic [width_p-1:0]          rx_data_s;
    logic                        unused_rx_s;

    // A start is honoured everywhere except while packets are in flight.
    assign start_ok_s  = start_i & (state_r != SEND);
    assign xfer_s      = v_r & link.link_i[0];
    assign rx_v_s      = link.link_i[lw-1];
    assign rx_data_s   = link.link_i[width_p:1];
    assign unused_rx_s = ^rx_data_s;

    // Send-side next state: FSM, packet counter and the registered outgoing beat.
    always_comb begin
        state_s  = state_r;
        num_s    = num_r;
        dest_x_s = dest_x_r;
        dest_y_s = dest_y_r;
        sent_s   = sent_r;
        v_s      = v_r;
        data_s   = data_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    num_s    = num_pkts_i;
                    dest_x_s = dest_x_i;
                    dest_y_s = dest_y_i;
                    sent_s   = cnt_zero;
                    data_s   = pack_f(cnt_zero, dest_y_i, dest_x_i);
                    if (num_pkts_i != cnt_zero) begin
                        state_s = SEND;
                        v_s     = 1'b1;
                    end else begin
                        state_s = DONE;
                        v_s     = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                    v_s     = 1'b0;
                end
            end
            SEND: begin
                if (xfer_s) begin
                    sent_s = sent_r + cnt_one;
                    if (sent_r == (num_r - cnt_one)) begin
                        state_s = DONE;
                        v_s     = 1'b0;
                    end else begin
                        state_s = SEND;
                        v_s     = 1'b1;
                        data_s  = pack_f(sent_r + cnt_one, dest_y_r, dest_x_r);
                    end
                end else begin
                    // Hold v and data stable until the router accepts the beat.
                    sent_s = sent_r;
                    v_s    = v_r;
                    data_s = data_r;
                end
            end
            default: begin
                state_s = IDLE;
                v_s     = 1'b0;
            end
        endcase
    end

    // Receive-side next state: count and sign every beat; a start clears and wins.
    always_comb begin
        recvd_s = recvd_r;
        sig_s   = sig_r;
        if (start_ok_s) begin
            recvd_s = cnt_zero;
            sig_s   = 32'd0;
        end else if (rx_v_s) begin
            recvd_s = recvd_r + cnt_one;
            sig_s   = sig_step_f(sig_r, rx_data_s[31:0]);
        end else begin
            recvd_s = recvd_r;
            sig_s   = sig_r;
        end
    end

    // Main state registers; link_o drops to all-zero on reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= IDLE;
            num_r    <= cnt_zero;
            dest_x_r <= '0;
            dest_y_r <= '0;
            sent_r   <= cnt_zero;
            v_r      <= 1'b0;
            data_r   <= '0;
            rdy_r    <= 1'b0;
            recvd_r  <= cnt_zero;
            sig_r    <= 32'd0;
        end else begin
            state_r  <= state_s;
            num_r    <= num_s;
            dest_x_r <= dest_x_s;
            dest_y_r <= dest_y_s;
            sent_r   <= sent_s;
            v_r      <= v_s;
            data_r   <= data_s;
            rdy_r    <= 1'b1;
            recvd_r  <= recvd_s;
            sig_r    <= sig_s;
        end
    end

`ifdef BSG_ROUTER_TGEN_CHECK_EN
    logic [count_width_p-1:0] exp_r, exp_s;
    logic                     error_r, error_s;
    logic [count_width_p-1:0] rx_seq_s;

    assign rx_seq_s = rx_data_s[coord_w +: count_width_p];

    // Expected-sequence tracker; a mismatch latches error until the next start.
    always_comb begin
        exp_s   = exp_r;
        error_s = error_r;
        if (start_ok_s) begin
            exp_s   = cnt_zero;
            error_s = 1'b0;
        end else if (rx_v_s) begin
            exp_s = exp_r + cnt_one;
            if (rx_seq_s != exp_r) begin
                error_s = 1'b1;
            end else begin
                error_s = error_r;
            end
        end else begin
            exp_s   = exp_r;
            error_s = error_r;
        end
    end

    // Checker registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            exp_r   <= cnt_zero;
            error_r <= 1'b0;
        end else begin
            exp_r   <= exp_s;
            error_r <= error_s;
        end
    end

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

    assign link.link_o = {v_r, data_r, rdy_r};
    assign busy_o      = (state_r == SEND);
    assign done_o      = (state_r == DONE);
    assign sent_o      = sent_r;
    assign recvd_o     = recvd_r;
    assign sig_o       = sig_r;

endmodule

// File: tb/tb_bsg_router_link_traffic_gen.sv
// Directed bench for bsg_router_link_traffic_gen: a vector table for the
// backpressure scenario plus hand-written sequences for loopback, num=0,
// start-during-send, reset mid-send and receive-order checking.
module tb_bsg_router_link_traffic_gen;
    localparam int W  = 128;
    localparam int LW = W + 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] num;
    logic [4:0]  dx;
    logic [4:0]  dy;
    logic        rdy_in;
    logic        loop_en;
    logic        inj_v;
    logic [W-1:0] inj_data;
    logic        lb_v;
    logic [W-1:0] lb_data;

    logic        busy, done, err;
    logic [15:0] sent, recvd;
    logic [31:0] sig;

    int checks = 0;
    int errors = 0;

    bsg_router_link_traffic_gen_if #(.width_p(W)) link_if ();

    bsg_router_link_traffic_gen #(
        .width_p(W), .x_cord_width_p(5), .y_cord_width_p(5), .count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .num_pkts_i(num),
        .dest_x_i(dx), .dest_y_i(dy), .link(link_if), .busy_o(busy),
        .done_o(done), .sent_o(sent), .recvd_o(recvd), .sig_o(sig), .error_o(err)
    );

    always #5 clk = ~clk;

    // One-flop loopback of our own output stream.
    always @(posedge clk) begin
        lb_v    <= link_if.link_o[LW-1];
        lb_data <= link_if.link_o[W:1];
    end

    assign link_if.link_i = loop_en ? {lb_v, lb_data, rdy_in} : {inj_v, inj_data, rdy_in};

    wire          out_v    = link_if.link_o[LW-1];
    wire [W-1:0]  out_data = link_if.link_o[W:1];
    wire          out_rdy  = link_if.link_o[0];

    function automatic logic [W-1:0] pkt(input logic [15:0] s, input logic [4:0] y, input logic [4:0] x);
        logic [W-1:0] p;
        p = '0;
        p[4:0]   = x;
        p[9:5]   = y;
        p[25:10] = s;
        return p;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n, input logic [4:0] x, input logic [4:0] y);
        @(negedge clk);
        start = 1'b1; num = n; dx = x; dy = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        logic        rdy;
        logic        exp_v;
        logic [15:0] exp_seq;
        logic [15:0] exp_sent;
        logic        exp_done;
    } vec_t;

    vec_t vecs[8];
    int   xfers;
    int   cyc;

    initial begin
        // Backpressure table for num=3, ready 1,0,0,1,0,1 (row k = state after accepting edge + k).
        vecs[0] = '{1'b1, 1'b1, 16'd0, 16'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'd1, 16'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'd1, 16'd1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'd1, 16'd1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 16'd2, 16'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'd2, 16'd2, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 16'd0, 16'd3, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'd0, 16'd3, 1'b1};

        reset_n = 1'b0; start = 1'b0; num = 16'd0; dx = 5'd0; dy = 5'd0;
        rdy_in = 1'b0; loop_en = 1'b0; inj_v = 1'b0; inj_data = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_link_o", link_if.link_o, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sent", sent, 16'd0);
        check("reset_recvd", recvd, 16'd0);
        check("reset_sig", sig, 32'd0);
        check("reset_error", err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check("sink_ready", out_rdy, 1'b1);

        // Loopback: num=4 to (3,2), ready always high.
        rdy_in = 1'b1; loop_en = 1'b1;
        do_start(16'd4, 5'd3, 5'd2);
        for (int i = 0; i < 4; i++) begin
            check("lb_v", out_v, 1'b1);
            check("lb_dx", out_data[4:0], 5'd3);
            check("lb_dy", out_data[9:5], 5'd2);
            check("lb_seq", out_data[25:10], 16'(i));
            @(negedge clk);
        end
        check("lb_v_drop", out_v, 1'b0);
        check("lb_done", done, 1'b1);
        check("lb_sent", sent, 16'd4);
        repeat (3) @(negedge clk);
        check("lb_recvd", recvd, 16'd4);
        check("lb_sig", sig, 32'h00000FD1);
        loop_en = 1'b0;

        // num=0: straight to DONE, never valid.
        do_start(16'd0, 5'd1, 5'd1);
        check("zero_done", done, 1'b1);
        check("zero_sent", sent, 16'd0);
        check("zero_recvd_clear", recvd, 16'd0);
        for (int i = 0; i < 3; i++) begin
            check("zero_no_v", out_v, 1'b0);
            @(negedge clk);
        end

        // Backpressure table.
        do_start(16'd3, 5'd5, 5'd6);
        for (int k = 0; k < 8; k++) begin
            check("tbl_v", out_v, vecs[k].exp_v);
            if (vecs[k].exp_v)
                check("tbl_data", out_data, pkt(vecs[k].exp_seq, 5'd6, 5'd5));
            check("tbl_sent", sent, vecs[k].exp_sent);
            check("tbl_done", done, vecs[k].exp_done);
            rdy_in = vecs[k].rdy;
            @(negedge clk);
        end

        // Start pulsed during SEND (num=8) is ignored.
        rdy_in = 1'b1;
        do_start(16'd8, 5'd1, 5'd2);
        xfers = 0;
        cyc = 0;
        while (!done && cyc < 40) begin
            if (out_v && rdy_in) xfers++;
            start = (cyc == 3);
            num   = 16'd2;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("ign_timeout", (cyc < 40), 1'b1);
        check("ign_xfers", xfers, 8);
        check("ign_sent", sent, 16'd8);
        check("ign_done", done, 1'b1);

        // Reset asserted mid-SEND with v held high.
        rdy_in = 1'b0;
        do_start(16'd8, 5'd4, 5'd4);
        @(negedge clk);
        check("mid_v_before", out_v, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_link_o", link_if.link_o, '0);
        check("mid_busy", busy, 1'b0);
        check("mid_sent", sent, 16'd0);
        check("mid_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_idle", {busy, done, out_v}, 3'b000);

        // Receive-order check: inject seq 0,1,3.
        do_start(16'd0, 5'd0, 5'd0);
        inj_v = 1'b1; inj_data = pkt(16'd0, 5'd0, 5'd0);
        @(negedge clk);
        inj_data = pkt(16'd1, 5'd0, 5'd0);
        check("ord_err0", err, 1'b0);
        @(negedge clk);
        inj_data = pkt(16'd3, 5'd0, 5'd0);
        check("ord_err1", err, 1'b0);
        @(negedge clk);
        inj_v = 1'b0; inj_data = '0;
        check("ord_recvd", recvd, 16'd3);
        check("ord_sig", sig, 32'h00000400);
`ifdef BSG_ROUTER_TGEN_CHECK_EN
        check("ord_err_rise", err, 1'b1);
        repeat (2) @(negedge clk);
        check("ord_err_sticky", err, 1'b1);
`else
        check("ord_err_tied", err, 1'b0);
        repeat (2) @(negedge clk);
        check("ord_err_tied2", err, 1'b0);
`endif
        do_start(16'd0, 5'd0, 5'd0);
        check("ord_err_clear", err, 1'b0);
        check("ord_recvd_clear", recvd, 16'd0);
        check("ord_sig_clear", sig, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
